gf180mcu_osu_sc_12t_clkdiv_inv: RTL and testbench
=================================================

Name: gf180mcu_osu_sc_12T_clkdiv_inv

Overview:
- Registered, programmable clock divider with selectable output polarity. It is the parametrised successor of the fixed clock inverter cell.
- Produces Y at CLK/(2*(DIV+1)) with run-time polarity select, glitch-free enable and reconfiguration, and a per-period TICK strobe.
- Sits in the clock-generation cell set. It drives local divided or inverted clock domains and strobe-based timers.

Parameters:
- DIV_W, 8, width of the divide-ratio field. Half-period = DIV+1 CLK cycles.
- INV_DEFAULT, 0, polarity after reset. 0 = idle-low Y, 1 = idle-high Y.

Ports:
- CLK  input  1  clock. All logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  run request. Level-sensitive.
- DIV  input  DIV_W  divide ratio. Sampled only on LOAD.
- INV  input  1  output polarity. Sampled only on LOAD.
- LOAD  input  1  one-cycle strobe that captures DIV/INV into the pending shadow.
- Y  output  1  divided clock. Registered, Y = phase XOR inv_act.
- TICK  output  1  one-cycle pulse on every phase 1->0 wrap, i.e. once per Y period.
- BUSY  output  1  high while a loaded configuration is pending.
- ACK  output  1  one-cycle pulse when pending configuration becomes active.

Behaviour:
- Reset (RST sampled 1):
  - cnt=0, phase=0, state=IDLE.
  - div_act=0, inv_act=INV_DEFAULT, pending cleared.
  - Y=INV_DEFAULT, TICK=0, BUSY=0, ACK=0.
  - RST mid-run aborts immediately and discards pending. No ACK is issued.
- States:
  - IDLE: phase=0, cnt=0, Y held at inv_act.
  - RUN.
  - STOPPING: EN dropped during the high half.
- IDLE -> RUN: on the edge where EN=1; cnt<=0.
- RUN counting: each edge, if cnt==div_act then cnt<=0 and phase toggles; else cnt+1.
  - First Y change occurs at edge k+DIV+1 after EN is sampled at edge k.
  - Every half-period is exactly div_act+1 cycles.
- RUN -> IDLE or STOPPING on EN=0:
  - If phase=0, go to IDLE at that edge. Y is already at idle level, so no runt pulse.
  - If phase=1, go to STOPPING. The high half completes its full length, then IDLE at the wrap.
  - EN=1 in STOPPING returns to RUN without disturbing the count.
- TICK: asserted in the cycle following each phase 1->0 wrap edge, including the final wrap of STOPPING.
- LOAD handling:
  - LOAD captures DIV/INV into the pending shadow.
  - In RUN/STOPPING: BUSY=1 from the next cycle. Pending is applied only at the next phase 1->0 wrap, where div_act and inv_act update on that edge. ACK pulses 1 cycle and BUSY clears on the same edge.
  - In IDLE: applied at the LOAD edge itself. Y takes the new idle level on that edge, ACK pulses next cycle, and BUSY never asserts.
- LOAD while BUSY: overwrites pending (last write wins). Only one ACK is issued.
- LOAD on the same edge as a qualifying wrap: the new value waits for the following wrap. Any earlier pending value is replaced, not applied.
- Polarity change at a wrap: Y does not toggle on that edge. The half is stretched, never shortened, so minimum Y pulse width ≥ min(old, new) half-period.
- DIV=0 gives CLK/2. DIV=2^DIV_W-1 gives the maximum half-period of 2^DIV_W cycles. No overflow is possible because cnt is DIV_W bits and compares against div_act.
- All outputs are registered. There is no combinational path from inputs to Y/TICK/BUSY/ACK.

Test Plan:
- Reset, then LOAD DIV=3 INV=0 in IDLE, then EN=1 at edge 10 -> ACK at cycle after LOAD, BUSY never high. Y rises at edge 14 and toggles every 4 edges. TICK every 8 cycles.
- DIV=0, EN=1 -> Y period 2 CLK, duty 50%. TICK every other cycle.
- Running DIV=3, LOAD DIV=1 INV=1 mid high-half -> BUSY high until the next 1->0 wrap. At the wrap, Y holds 1 for one extra half (no toggle), then period 4. ACK single pulse.
- EN=0 at cnt=1 of high half (DIV=3) -> Y stays high 2 more edges, falls at the wrap, one TICK, then IDLE with Y=0. EN=0 during low half -> immediate IDLE, Y unchanged.
- Two LOADs while BUSY (DIV=5 then DIV=2) -> after the wrap div_act=2, exactly one ACK.
- RST asserted while BUSY and Y high -> next edge: Y=INV_DEFAULT, BUSY=0, no ACK. Subsequent EN runs with div_act=0.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_inv.sv
// Programmable registered clock divider: Y = CLK/(2*(div_act+1)) with selectable
// polarity, glitch-free stop, and reconfiguration deferred to the high->low wrap.
module gf180mcu_osu_sc_12t_clkdiv_inv #(
   parameter int DIV_W       = 8,
   parameter bit INV_DEFAULT = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [DIV_W-1:0] DIV,
   input  logic             INV,
   input  logic             LOAD,
   output logic             Y,
   output logic             TICK,
   output logic             BUSY,
   output logic             ACK,
   output logic [1:0]       state_dbg
);

   // Config handshake: LOAD is a one-cycle strobe that is always accepted (no
   // ready). BUSY is high while a captured value waits for the next wrap, and
   // ACK pulses for one cycle in the cycle after it becomes active.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_act;
   logic [DIV_W-1:0] pend_div;
   logic             phase;
   logic             inv_act;
   logic             pend_inv;

   logic             at_end;
   logic             stop_now;
   logic             counting;
   logic             wrap;
   logic             apply;
   logic             nxt_phase;
   logic             nxt_inv;

   assign state_dbg = state;

   always_comb begin
      at_end    = (cnt == div_act);
      stop_now  = (state == RUN) && !EN && !phase;
      counting  = (state != IDLE) && !stop_now;
      wrap      = counting && phase && at_end;
      // A LOAD on the wrap edge replaces the pending value instead of applying it.
      apply     = wrap && BUSY && !LOAD;
      nxt_phase = 1'b0;
      if (counting) begin
         nxt_phase = at_end ? ~phase : phase;
      end
      nxt_inv = inv_act;
      if ((state == IDLE) && LOAD) begin
         nxt_inv = INV;
      end else if (apply) begin
         nxt_inv = pend_inv;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         phase    <= 1'b0;
         div_act  <= '0;
         inv_act  <= INV_DEFAULT;
         pend_div <= '0;
         pend_inv <= INV_DEFAULT;
         Y        <= INV_DEFAULT;
         TICK     <= 1'b0;
         BUSY     <= 1'b0;
         ACK      <= 1'b0;
      end else begin
         TICK    <= wrap;
         ACK     <= apply || ((state == IDLE) && LOAD);
         phase   <= nxt_phase;
         inv_act <= nxt_inv;
         // Polarity change at a wrap leaves Y steady, stretching the half.
         Y       <= nxt_phase ^ nxt_inv;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (LOAD) begin
                  div_act <= DIV;
                  BUSY    <= 1'b0;
               end
               if (EN) begin
                  state <= RUN;
               end
            end
            default: begin
               if (stop_now) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= at_end ? '0 : cnt + 1'b1;
                  if (wrap) begin
                     state <= EN ? RUN : IDLE;
                  end else begin
                     state <= EN ? RUN : STOPPING;
                  end
                  if (apply) begin
                     div_act <= pend_div;
                     BUSY    <= 1'b0;
                  end
               end
               if (LOAD) begin
                  pend_div <= DIV;
                  pend_inv <= INV;
                  BUSY     <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv_inv.sv
// Bench for the programmable clock divider: directed scenarios plus random
// traffic, checked against a half-period countdown model.
module tb_gf180mcu_osu_sc_12t_clkdiv_inv;

   localparam int DIV_W = 8;
   localparam bit INV_DEFAULT = 1'b0;

   logic             CLK = 1'b0;
   logic             RST, EN, INV, LOAD;
   logic [DIV_W-1:0] DIV;
   logic             Y, TICK, BUSY, ACK;
   logic [1:0]       state_dbg;

   int total = 0;
   int bad   = 0;

   // model: mode 0 idle, 1 run, 2 stopping; left = cycles remaining in current half
   int   m_mode, m_left, m_div, m_pdiv;
   logic m_hi, m_inv, m_pinv, m_pend;
   logic m_y, m_tick, m_busy, m_ack;

   gf180mcu_osu_sc_12t_clkdiv_inv #(.DIV_W(DIV_W), .INV_DEFAULT(INV_DEFAULT)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV), .INV(INV), .LOAD(LOAD),
      .Y(Y), .TICK(TICK), .BUSY(BUSY), .ACK(ACK), .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;

   task automatic model_edge(input logic rst, input logic en, input logic ld,
                             input int d, input logic iv);
      logic was_hi;
      if (rst) begin
         m_mode = 0; m_left = 0; m_hi = 1'b0; m_div = 0; m_inv = INV_DEFAULT;
         m_pend = 1'b0; m_pdiv = 0; m_pinv = INV_DEFAULT;
         m_tick = 1'b0; m_ack = 1'b0;
      end else begin
         m_tick = 1'b0;
         m_ack  = 1'b0;
         if (m_mode == 0) begin
            if (ld) begin
               m_div = d; m_inv = iv; m_pend = 1'b0; m_ack = 1'b1;
            end
            if (en) begin
               m_mode = 1; m_hi = 1'b0; m_left = m_div + 1;
            end
         end else begin
            if (m_mode == 1 && !en && !m_hi) begin
               m_mode = 0;
            end else begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  was_hi = m_hi;
                  m_hi = !m_hi;
                  if (was_hi) begin
                     m_tick = 1'b1;
                     if (m_pend && !ld) begin
                        m_div = m_pdiv; m_inv = m_pinv; m_pend = 1'b0; m_ack = 1'b1;
                     end
                     m_mode = en ? 1 : 0;
                  end
                  m_left = m_div + 1;
               end else begin
                  m_mode = en ? 1 : 2;
               end
            end
            if (ld) begin
               m_pdiv = d; m_pinv = iv; m_pend = 1'b1;
            end
         end
      end
      m_busy = m_pend;
      m_y    = m_hi ^ m_inv;
   endtask

   task automatic check_outputs();
      total++;
      assert (Y === m_y) else begin
         bad++; $error("FAIL y: got %b expected %b at %0t", Y, m_y, $time);
      end
      total++;
      assert (TICK === m_tick) else begin
         bad++; $error("FAIL tick: got %b expected %b at %0t", TICK, m_tick, $time);
      end
      total++;
      assert (BUSY === m_busy) else begin
         bad++; $error("FAIL busy: got %b expected %b at %0t", BUSY, m_busy, $time);
      end
      total++;
      assert (ACK === m_ack) else begin
         bad++; $error("FAIL ack: got %b expected %b at %0t", ACK, m_ack, $time);
      end
   endtask

   // One clock: drive, let the edge happen, advance the model, check 1 ns later.
   task automatic step(input logic rst, input logic en, input logic ld,
                       input int d, input logic iv);
      RST = rst; EN = en; LOAD = ld; DIV = DIV_W'(d); INV = iv;
      @(posedge CLK);
      model_edge(rst, en, ld, d, iv);
      #1;
      check_outputs();
   endtask

   task automatic idle_steps(input logic en, input int n);
      for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 1'b0);
   endtask

   // Advance with EN held until the model reaches the requested Y level.
   task automatic wait_level(input logic en, input logic lvl);
      int guard;
      guard = 0;
      while (m_y !== lvl && guard < 600) begin
         step(1'b0, en, 1'b0, 0, 1'b0);
         guard++;
      end
      total++;
      assert (guard < 600) else begin
         bad++; $error("FAIL wait_level: got timeout expected level %b", lvl);
      end
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; LOAD = 1'b0; DIV = '0; INV = 1'b0;
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);

      // DIV=3 loaded while idle, run started a few edges later
      step(1'b0, 1'b0, 1'b1, 3, 1'b0);
      idle_steps(1'b0, 3);
      idle_steps(1'b1, 24);
      idle_steps(1'b0, 6);

      // DIV=0: CLK/2
      step(1'b0, 1'b0, 1'b1, 0, 1'b0);
      idle_steps(1'b1, 10);

      // reconfigure mid high half of a DIV=3 run to DIV=1 INV=1
      step(1'b0, 1'b1, 1'b1, 3, 1'b0);
      idle_steps(1'b1, 3);
      wait_level(1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1, 1'b1);
      idle_steps(1'b1, 16);

      // stop requests during high and low halves
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3, 1'b0);
      idle_steps(1'b1, 1);
      wait_level(1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 0, 1'b0);
      idle_steps(1'b0, 6);
      idle_steps(1'b1, 2);
      idle_steps(1'b0, 3);

      // two loads while busy: last one wins, single ack
      idle_steps(1'b1, 1);
      wait_level(1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 5, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2, 1'b0);
      idle_steps(1'b1, 20);

      // reset while busy with Y high
      wait_level(1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 4, 1'b0);
      step(1'b1, 1'b1, 1'b0, 0, 1'b0);
      idle_steps(1'b1, 8);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4)),
              $urandom_range(0, 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
